// File: rtl/mem_stage_sequencer_if.sv
// Bundle between the pipeline MEM stage, the sequencer and the memory controller.
// The master side drives requests and read data; the slave is the sequencer.
interface mem_stage_sequencer_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mc_we;
  logic [31:0] mc_address;
  logic [31:0] mc_wd;
  logic [31:0] mc_rd;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mc_rd,
    input  mc_we, mc_address, mc_wd, stall, done, rdata, fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mc_rd,
    output mc_we, mc_address, mc_wd, stall, done, rdata, fault
  );
endinterface

// File: rtl/mem_stage_sequencer.sv
// Sequences one MEM-stage load/store onto a ROM (combinational read) / RAM (one-cycle read)
// memory controller, flags illegal accesses and keeps saturating event counters.
module mem_stage_sequencer #(
  parameter logic [31:0] ROM_BASE = 32'd400,
  parameter logic [31:0] RAM_BASE = 32'd8500,
  parameter logic [31:0] RAM_END  = 32'd138100,
  parameter int          STAT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_stage_sequencer_if.slave  bus,
  output logic [STAT_W-1:0]     stat_reads,
  output logic [STAT_W-1:0]     stat_writes,
  output logic [STAT_W-1:0]     stat_faults
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        we_q, we_d;
  logic        is_rom, is_ram;
  logic        done_c, mc_we_c;
  logic [2:0]  cnt_inc;  // bit0 reads, bit1 writes, bit2 faults

  assign is_rom = (bus.req_addr >= ROM_BASE) && (bus.req_addr < RAM_BASE);
  assign is_ram = (bus.req_addr >= RAM_BASE) && (bus.req_addr < RAM_END);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rdata_d        = rdata_q;
    fault_d        = fault_q;
    we_d           = we_q;
    mc_we_c        = 1'b0;
    done_c         = 1'b0;
    cnt_inc        = 3'b000;
    bus.mc_address = addr_q;
    case (state_q)
      IDLE: begin
        bus.mc_address = bus.req_addr;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          fault_d = 1'b0;
          if (!bus.req_we && is_rom) begin
            rdata_d = bus.mc_rd;
            state_d = DONE;
          end else if (!bus.req_we && is_ram) begin
            state_d = RAM_WAIT;
          end else if (bus.req_we && is_ram) begin
            // Gated so a store held during reset never reaches the controller.
            mc_we_c = rst_n;
            state_d = DONE;
          end else begin
            fault_d = 1'b1;
            rdata_d = 32'd0;
            state_d = DONE;
          end
        end
      end
      RAM_WAIT: begin
        rdata_d = bus.mc_rd;
        state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
        cnt_inc = fault_q ? 3'b100 : (we_q ? 3'b010 : 3'b001);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      we_q    <= we_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [STAT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi] && (cnt_q != {STAT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign stat_reads  = g_cnt[0].cnt_q;
  assign stat_writes = g_cnt[1].cnt_q;
  assign stat_faults = g_cnt[2].cnt_q;

  assign bus.mc_we = mc_we_c;
  assign bus.mc_wd = bus.req_wdata;
  assign bus.done  = done_c;
  assign bus.stall = bus.req_valid & ~done_c;
  assign bus.fault = done_c & fault_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Randomized bench: a transaction-level model predicts every output on each falling edge,
// with a few literal checks pinning the model on directed accesses.
module tb_mem_stage_sequencer;

  logic clk;
  logic rst_n;

  mem_stage_sequencer_if bus ();
  mem_stage_sequencer_if sif ();

  logic [15:0] stat_reads, stat_writes, stat_faults;
  logic [3:0]  sat_reads, sat_writes, sat_faults;

  mem_stage_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
    .stat_faults(stat_faults)
  );

  // Narrow-counter copy so saturation is reached in a few dozen accesses.
  mem_stage_sequencer #(.STAT_W(4)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (sif),
    .stat_reads (sat_reads),
    .stat_writes(sat_writes),
    .stat_faults(sat_faults)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Current transaction as seen by the model.
  bit          t_active = 1'b0;
  int          t_k = 0;
  int          t_len = 0;
  logic        t_we = 1'b0;
  logic        t_ram = 1'b0;
  logic        t_fault = 1'b0;
  logic [31:0] t_addr = 32'd0;

  logic [31:0] m_rdata = 32'd0;
  int          m_reads = 0, m_writes = 0, m_faults = 0;

  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rd = 32'd0;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(negedge clk) begin
    bit exp_done;
    if (!rst_n) begin
      m_rdata = 32'd0;
      m_reads = 0; m_writes = 0; m_faults = 0;
      chk("rst_done",  {31'd0, bus.done},  32'd0);
      chk("rst_mc_we", {31'd0, bus.mc_we}, 32'd0);
      chk("rst_fault", {31'd0, bus.fault}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, {31'd0, bus.req_valid});
      chk("rst_stats", {stat_reads, stat_writes}, 32'd0);
      chk("rst_statf", {16'd0, stat_faults}, 32'd0);
    end else begin
      exp_done = t_active && (t_k == t_len);
      chk("done",       {31'd0, bus.done}, {31'd0, exp_done});
      chk("mc_we",      {31'd0, bus.mc_we}, {31'd0, t_active && t_k == 1 && t_we && t_ram});
      chk("fault",      {31'd0, bus.fault}, {31'd0, exp_done && t_fault});
      chk("stall",      {31'd0, bus.stall}, {31'd0, bus.req_valid && !exp_done});
      chk("mc_address", bus.mc_address, t_active ? t_addr : bus.req_addr);
      chk("mc_wd",      bus.mc_wd, bus.req_wdata);
      chk("rdata",      bus.rdata, m_rdata);
      chk("stat_reads",  {16'd0, stat_reads},  m_reads);
      chk("stat_writes", {16'd0, stat_writes}, m_writes);
      chk("stat_faults", {16'd0, stat_faults}, m_faults);
      // The read result is whatever the controller returns in the last cycle before done.
      if (t_active && t_k == t_len - 1) begin
        if (t_fault)    m_rdata = 32'd0;
        else if (!t_we) m_rdata = bus.mc_rd;
      end
      if (exp_done) begin
        if (t_fault)   m_faults = sat16(m_faults);
        else if (t_we) m_writes = sat16(m_writes);
        else           m_reads  = sat16(m_reads);
      end
    end
  end

  function automatic logic [31:0] next_rd();
    return use_fixed ? fixed_rd : $urandom;
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit drop);
    logic rom;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.mc_rd     = next_rd();
    rom     = (addr >= 32'd400)  && (addr < 32'd8500);
    t_ram   = (addr >= 32'd8500) && (addr < 32'd138100);
    t_fault = !(t_ram || (rom && !we));
    t_len   = (t_ram && !we) ? 3 : 2;
    t_we    = we;
    t_addr  = addr;
    t_k     = 1;
    t_active = 1'b1;
    for (int k = 2; k <= t_len; k++) begin
      @(posedge clk); #1;
      if (drop) begin
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
      end
      bus.mc_rd     = next_rd();
      bus.req_wdata = $urandom;
      t_k = k;
    end
    @(posedge clk); #1;
    t_active      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.mc_rd     = $urandom;
    $display("txn we=%0b addr=%0d drop=%0b len=%0d rdata=%h", we, addr, drop, t_len, bus.rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.mc_rd     = $urandom;
    end
  endtask

  logic [31:0] bnd [6] = '{32'd399, 32'd400, 32'd8499, 32'd8500, 32'd138099, 32'd138100};

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 32'd400 + 32'($urandom_range(0, 8099));
      1: return 32'd8500 + 32'($urandom_range(0, 129599));
      2: return 32'($urandom_range(0, 399));
      3: return $urandom;
      4: return bnd[$urandom_range(0, 5)];
      default: return 32'd8500 + 32'($urandom_range(0, 129599));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.mc_rd = 32'd0;
    sif.req_valid = 1'b0; sif.req_we = 1'b0; sif.req_addr = 32'd0;
    sif.req_wdata = 32'd0; sif.mc_rd = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed ROM load from the first ROM byte.
    use_fixed = 1'b1; fixed_rd = 32'hCAFE0001;
    run_txn(1'b0, 32'd400, 32'd0, 1'b0);
    chk("pin_rom_rdata", bus.rdata, 32'hCAFE0001);
    chk("pin_rom_reads", {16'd0, stat_reads}, 32'd1);
    // Directed RAM load from the first RAM byte.
    fixed_rd = 32'h0BADF00D;
    run_txn(1'b0, 32'd8500, 32'd0, 1'b0);
    use_fixed = 1'b0;
    chk("pin_ram_rdata", bus.rdata, 32'h0BADF00D);
    // Directed RAM store near the top of RAM must leave rdata alone.
    run_txn(1'b1, 32'd138096, 32'h12345678, 1'b0);
    chk("pin_st_rdata",  bus.rdata, 32'h0BADF00D);
    chk("pin_st_writes", {16'd0, stat_writes}, 32'd1);
    // Three illegal accesses.
    run_txn(1'b1, 32'd400, 32'hDEADBEEF, 1'b0);
    run_txn(1'b0, 32'd138100, 32'd0, 1'b0);
    run_txn(1'b0, 32'd8, 32'd0, 1'b0);
    chk("pin_faults",      {16'd0, stat_faults}, 32'd3);
    chk("pin_fault_rdata", bus.rdata, 32'd0);
    chk("pin_reads_after", {16'd0, stat_reads}, 32'd2);

    // Reset in the middle of a RAM load.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd9000; bus.mc_rd = $urandom;
    t_addr = 32'd9000; t_we = 1'b0; t_ram = 1'b1; t_fault = 1'b0; t_len = 3; t_k = 1;
    t_active = 1'b1;
    @(posedge clk); #1;
    t_k = 2;
    #2;
    rst_n = 1'b0;
    t_active = 1'b0;
    // A RAM store held during reset must not pulse mc_we.
    bus.req_we = 1'b1; bus.req_addr = 32'd10000;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    chk("pin_rst_reads", {16'd0, stat_reads}, 32'd0);
    run_txn(1'b0, 32'd8500, 32'd0, 1'b0);
    chk("pin_rst_reload", {16'd0, stat_reads}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom), pick_addr(), $urandom, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end

    // Continuous ROM loads on the narrow-counter instance.
    chk("sat_init", {28'd0, sat_reads}, 32'd0);
    @(posedge clk); #1;
    sif.req_valid = 1'b1; sif.req_we = 1'b0; sif.req_addr = 32'd500; sif.mc_rd = 32'h1;
    repeat (40) @(posedge clk);
    #1;
    chk("sat_reads",  {28'd0, sat_reads}, 32'd15);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold",   {28'd0, sat_reads}, 32'd15);
    chk("sat_writes", {28'd0, sat_writes}, 32'd0);
    chk("sat_faults", {28'd0, sat_faults}, 32'd0);
    sif.req_valid = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
